// File: rtl/watch_time_counter.sv
// Watch timekeeping core: binary calendar/time advanced once per clk1sec edge.
// Loads clamped bin_time while en_time is high; load wins over a tick.
module watch_time_counter #(
    parameter int YEAR_MAX = 199
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk1sec,
    input  logic        en_time,
    input  logic [47:0] bin_time,
    output logic [7:0]  year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  second,
    output logic        sec_tick
);

    localparam logic [7:0] YMAX = YEAR_MAX[7:0];

    logic [7:0] year_q, month_q, day_q, hour_q, min_q, sec_q;
    logic [7:0] year_d, month_d, day_d, hour_d, min_d, sec_d;
    logic       tick_q, tick_d;
    logic       s1_q, s2_q, s3_q;
    logic       tick;

    function automatic logic [7:0] dim(input logic [7:0] m, input logic [7:0] y);
        logic leap;
        leap = (y[1:0] == 2'b00) && (y != 8'd100);
        case (m)
            8'd4, 8'd6, 8'd9, 8'd11: dim = 8'd30;
            8'd2:                    dim = leap ? 8'd29 : 8'd28;
            default:                 dim = 8'd31;
        endcase
    endfunction

    assign tick = s2_q & ~s3_q;

    logic [7:0] ld_yr, ld_mon, ld_day, ld_hr, ld_min, ld_sec, ld_dmax;

    always_comb begin
        ld_yr   = (bin_time[47:40] > YMAX) ? YMAX : bin_time[47:40];
        ld_mon  = bin_time[39:32];
        if (ld_mon == 8'd0)
            ld_mon = 8'd1;
        else if (ld_mon > 8'd12)
            ld_mon = 8'd12;
        ld_dmax = dim(ld_mon, ld_yr);
        ld_day  = bin_time[31:24];
        if (ld_day == 8'd0)
            ld_day = 8'd1;
        else if (ld_day > ld_dmax)
            ld_day = ld_dmax;
        ld_hr   = (bin_time[23:16] > 8'd23) ? 8'd23 : bin_time[23:16];
        ld_min  = (bin_time[15:8] > 8'd59) ? 8'd59 : bin_time[15:8];
        ld_sec  = (bin_time[7:0] > 8'd59) ? 8'd59 : bin_time[7:0];
    end

    always_comb begin
        year_d  = year_q;
        month_d = month_q;
        day_d   = day_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tick_d  = 1'b0;
        if (en_time) begin
            year_d  = ld_yr;
            month_d = ld_mon;
            day_d   = ld_day;
            hour_d  = ld_hr;
            min_d   = ld_min;
            sec_d   = ld_sec;
        end else if (tick) begin
            tick_d = 1'b1;
            sec_d  = sec_q + 8'd1;
            // Carries ripple combinationally so every field settles in one edge
            if (sec_q == 8'd59) begin
                sec_d = 8'd0;
                min_d = min_q + 8'd1;
                if (min_q == 8'd59) begin
                    min_d  = 8'd0;
                    hour_d = hour_q + 8'd1;
                    if (hour_q == 8'd23) begin
                        hour_d = 8'd0;
                        day_d  = day_q + 8'd1;
                        if (day_q == dim(month_q, year_q)) begin
                            day_d   = 8'd1;
                            month_d = month_q + 8'd1;
                            if (month_q == 8'd12) begin
                                month_d = 8'd1;
                                year_d  = (year_q == YMAX) ? 8'd0 : year_q + 8'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            tick_q  <= 1'b0;
            year_q  <= 8'd0;
            month_q <= 8'd1;
            day_q   <= 8'd1;
            hour_q  <= 8'd0;
            min_q   <= 8'd0;
            sec_q   <= 8'd0;
        end else begin
            s1_q    <= clk1sec;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            tick_q  <= tick_d;
            year_q  <= year_d;
            month_q <= month_d;
            day_q   <= day_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
        end
    end

    assign year     = year_q;
    assign month    = month_q;
    assign day      = day_q;
    assign hour     = hour_q;
    assign minute   = min_q;
    assign second   = sec_q;
    assign sec_tick = tick_q;

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed bench for watch_time_counter: rollover, leap years, load clamping,
// load priority, tick latency and asynchronous reset.
module tb_watch_time_counter;

    logic        clk;
    logic        rst;
    logic        clk1sec;
    logic        en_time;
    logic [47:0] bin_time;
    logic [7:0]  year, month, day, hour, minute, second;
    logic        sec_tick;

    int checks = 0;
    int errors = 0;

    watch_time_counter #(.YEAR_MAX(199)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk1sec  (clk1sec),
        .en_time  (en_time),
        .bin_time (bin_time),
        .year     (year),
        .month    (month),
        .day      (day),
        .hour     (hour),
        .minute   (minute),
        .second   (second),
        .sec_tick (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] t(input int y, input int mo, input int d,
                                      input int h, input int mi, input int s);
        t = {y[7:0], mo[7:0], d[7:0], h[7:0], mi[7:0], s[7:0]};
    endfunction

    task automatic chk_time(input string tag, input logic [47:0] exp);
        logic [47:0] obs;
        obs = {year, month, day, hour, minute, second};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d-%0d-%0d %0d:%0d:%0d expected %0d-%0d-%0d %0d:%0d:%0d",
                   tag, obs[47:40], obs[39:32], obs[31:24], obs[23:16], obs[15:8], obs[7:0],
                   exp[47:40], exp[39:32], exp[31:24], exp[23:16], exp[15:8], exp[7:0]);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called at a negedge; checks sec_tick latency (3 edges) and width (1 cycle)
    task automatic one_tick(input logic exp_pulse);
        clk1sec = 1'b1;
        repeat (2) @(negedge clk);
        chk_bit("tick_early", sec_tick, 1'b0);
        @(negedge clk);
        chk_bit("tick_pulse", sec_tick, exp_pulse);
        @(negedge clk);
        chk_bit("tick_width", sec_tick, 1'b0);
        clk1sec = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic load(input logic [47:0] b);
        en_time  = 1'b1;
        bin_time = b;
        @(negedge clk);
        en_time  = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        clk1sec  = 1'b0;
        en_time  = 1'b0;
        bin_time = '0;
        repeat (2) @(negedge clk);
        chk_time("reset_vals", t(0, 1, 1, 0, 0, 0));
        chk_bit("reset_tick", sec_tick, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        repeat (3) one_tick(1'b1);
        chk_time("three_sec", t(0, 1, 1, 0, 0, 3));

        load(t(23, 12, 31, 23, 59, 59));
        chk_time("load_nye", t(23, 12, 31, 23, 59, 59));
        one_tick(1'b1);
        chk_time("new_year", t(24, 1, 1, 0, 0, 0));

        load(t(24, 2, 28, 23, 59, 59));
        one_tick(1'b1);
        chk_time("leap_24", t(24, 2, 29, 0, 0, 0));
        load(t(100, 2, 28, 23, 59, 59));
        one_tick(1'b1);
        chk_time("noleap_100", t(100, 3, 1, 0, 0, 0));
        load(t(0, 2, 28, 23, 59, 59));
        one_tick(1'b1);
        chk_time("leap_0", t(0, 2, 29, 0, 0, 0));
        load(t(23, 2, 28, 23, 59, 59));
        one_tick(1'b1);
        chk_time("noleap_23", t(23, 3, 1, 0, 0, 0));
        load(t(199, 12, 31, 23, 59, 59));
        one_tick(1'b1);
        chk_time("year_wrap", t(0, 1, 1, 0, 0, 0));
        load(t(5, 4, 30, 23, 59, 59));
        one_tick(1'b1);
        chk_time("apr_end", t(5, 5, 1, 0, 0, 0));

        load(t(250, 0, 40, 30, 70, 99));
        chk_time("clamp_all", t(199, 1, 31, 23, 59, 59));
        load(t(1, 2, 31, 0, 0, 0));
        chk_time("clamp_feb", t(1, 2, 28, 0, 0, 0));
        load(t(24, 2, 31, 0, 0, 0));
        chk_time("clamp_feb_leap", t(24, 2, 29, 0, 0, 0));
        load(t(100, 13, 0, 0, 0, 0));
        chk_time("clamp_mon_day", t(100, 12, 1, 0, 0, 0));
        load(t(7, 9, 31, 5, 6, 7));
        chk_time("clamp_sep", t(7, 9, 30, 5, 6, 7));

        en_time  = 1'b1;
        bin_time = t(5, 6, 30, 10, 20, 30);
        @(negedge clk);
        one_tick(1'b0);
        chk_time("hold_load", t(5, 6, 30, 10, 20, 30));
        bin_time = t(6, 7, 4, 10, 20, 30);
        @(negedge clk);
        chk_time("hold_track", t(6, 7, 4, 10, 20, 30));
        en_time = 1'b0;
        @(negedge clk);
        chk_time("hold_release", t(6, 7, 4, 10, 20, 30));
        one_tick(1'b1);
        chk_time("after_hold", t(6, 7, 4, 10, 20, 31));

        load(t(5, 6, 15, 12, 34, 55));
        one_tick(1'b1);
        chk_time("pre_reset", t(5, 6, 15, 12, 34, 56));
        #2 rst = 1'b0;
        #1;
        chk_time("async_reset", t(0, 1, 1, 0, 0, 0));
        chk_bit("async_reset_tick", sec_tick, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        one_tick(1'b1);
        chk_time("post_reset", t(0, 1, 1, 0, 0, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
